// File: rtl/bi_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bi_buf_pkg
// Description : Shared types and constants for the bidirectional buffer
//               sequencer (state encoding, direction codes, counter widths).
// Revision    : 1.0  initial release
// ============================================================================
package bi_buf_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        XFER_A = 2'd2,
        XFER_B = 2'd3
    } state_t;

    // Buffer direction codes driven on en
    localparam logic DIR_A2B = 1'b1;
    localparam logic DIR_B2A = 1'b0;

    // Counter widths
    localparam int TURN_CNT_W  = 4;
    localparam int BURST_CNT_W = 8;

endpackage : bi_buf_pkg
`default_nettype wire

// File: rtl/bi_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bi_buf_ctrl
// Description : Half-duplex direction sequencer for a shared bidirectional
//               buffer. Arbitrates req_a/req_b round-robin, drives en/oe and
//               inserts TURN_CYCLES high-Z cycles on every direction change.
//               Optional burst limit: define BI_BUF_CTRL_BURST_LIMIT_EN to
//               force a handover after MAX_BURST contended owner cycles.
// Revision    : 1.0  initial release
// ============================================================================
module bi_buf_ctrl
    import bi_buf_pkg::*;
#(
    parameter int TURN_CYCLES = 2,   // 1..15
    parameter int MAX_BURST   = 8    // 1..255, burst-limit builds only
) (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic en,
    output logic oe,
    output logic busy
);

    localparam logic [TURN_CNT_W-1:0] C_TURN_LOAD = TURN_CNT_W'(TURN_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_en;
    logic                    w_en_nxt;
    logic                    r_last;        // direction code of the side served last
    logic                    w_last_nxt;
    logic [TURN_CNT_W-1:0]   r_turn_cnt;
    logic [TURN_CNT_W-1:0]   w_turn_cnt_nxt;
    logic                    r_gnt_a;
    logic                    r_gnt_b;
    logic                    r_oe;
    logic                    r_busy;

    logic                    w_tgt;
    logic                    w_req_own;     // request from the side en currently points at
    logic                    w_req_oth;     // request from the opposite side
    logic                    w_enter_xfer;
    logic                    w_force;       // burst limit reached, hand over now

    // Requests seen relative to the current direction
    assign w_req_own = (r_en == DIR_A2B) ? req_a : req_b;
    assign w_req_oth = (r_en == DIR_A2B) ? req_b : req_a;

`ifdef BI_BUF_CTRL_BURST_LIMIT_EN
    localparam logic [BURST_CNT_W-1:0] C_BURST_LAST = BURST_CNT_W'(MAX_BURST - 1);

    logic [BURST_CNT_W-1:0] r_burst_cnt;
    logic                   w_in_xfer;

    assign w_in_xfer = (r_state == XFER_A) || (r_state == XFER_B);
    // The cycle that would be the MAX_BURST-th contended one forces the handover
    assign w_force   = w_in_xfer && w_req_oth && (r_burst_cnt >= C_BURST_LAST);

    // Count owner cycles during which the other side is kept waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst_cnt <= '0;
        end else if (w_enter_xfer) begin
            r_burst_cnt <= '0;
        end else if (w_in_xfer && w_req_oth) begin
            r_burst_cnt <= r_burst_cnt + BURST_CNT_W'(1);
        end
    end
`else
    logic w_unused;

    // Owner keeps the bus until it drops its request
    assign w_force  = 1'b0;
    assign w_unused = (MAX_BURST != 0) ^ w_enter_xfer;
`endif

    // Next-state, direction, turnaround counter and round-robin pointer
    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_last_nxt     = r_last;
        w_turn_cnt_nxt = r_turn_cnt;
        w_enter_xfer   = 1'b0;
        w_tgt          = r_en;

        case (r_state)
            IDLE: begin
                if (req_a || req_b) begin
                    // On a tie serve the side opposite the one served last
                    w_tgt = (req_a && req_b) ? ~r_last : req_a;
                    if (w_tgt == r_en) begin
                        w_state_nxt  = (w_tgt == DIR_A2B) ? XFER_A : XFER_B;
                        w_last_nxt   = w_tgt;
                        w_enter_xfer = 1'b1;
                    end else begin
                        w_state_nxt    = TURN;
                        w_en_nxt       = w_tgt;
                        w_turn_cnt_nxt = C_TURN_LOAD;
                    end
                end
            end

            TURN: begin
                if (r_turn_cnt != '0) begin
                    w_turn_cnt_nxt = r_turn_cnt - TURN_CNT_W'(1);
                end else if (w_req_own) begin
                    w_state_nxt  = (r_en == DIR_A2B) ? XFER_A : XFER_B;
                    w_last_nxt   = r_en;
                    w_enter_xfer = 1'b1;
                end else if (w_req_oth) begin
                    w_state_nxt    = TURN;
                    w_en_nxt       = ~r_en;
                    w_turn_cnt_nxt = C_TURN_LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end

            XFER_A, XFER_B: begin
                // en always points at the owner while transferring
                if (!w_req_own || w_force) begin
                    if (w_req_oth) begin
                        w_state_nxt    = TURN;
                        w_en_nxt       = ~r_en;
                        w_turn_cnt_nxt = C_TURN_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_en       <= DIR_B2A;
            r_last     <= DIR_B2A;
            r_turn_cnt <= '0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_last     <= w_last_nxt;
            r_turn_cnt <= w_turn_cnt_nxt;
            r_gnt_a    <= (w_state_nxt == XFER_A);
            r_gnt_b    <= (w_state_nxt == XFER_B);
            r_oe       <= (w_state_nxt == XFER_A) || (w_state_nxt == XFER_B);
            r_busy     <= (w_state_nxt != IDLE);
        end
    end

    assign gnt_a = r_gnt_a;
    assign gnt_b = r_gnt_b;
    assign en    = r_en;
    assign oe    = r_oe;
    assign busy  = r_busy;

endmodule : bi_buf_ctrl
`default_nettype wire

// File: tb/tb_bi_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bi_buf_ctrl
// Description : Self-checking bench for bi_buf_ctrl: directed vector table,
//               burst/hold sequence and randomized traffic against a
//               behavioural ownership model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bi_buf_ctrl;

    localparam int TURN = 2;
    localparam int MAXB = 4;
    localparam int NVEC = 29;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic gnt_a;
    logic gnt_b;
    logic en;
    logic oe;
    logic busy;

    bi_buf_ctrl #(
        .TURN_CYCLES (TURN),
        .MAX_BURST   (MAXB)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .req_a (req_a),
        .req_b (req_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .en    (en),
        .oe    (oe),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    wire [4:0] dut_o = {gnt_a, gnt_b, en, oe, busy};

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: who owns the bus, where it points, how long the
    // current high-Z gap still lasts, and how long the waiter has waited.
    int m_phase;   // 0 = nobody, 1 = changing direction, 2 = owned
    bit m_dir;     // 1 = A side, 0 = B side
    bit m_last;
    int m_left;
    int m_cont;

    function automatic logic [4:0] model_out();
        bit own;
        own = (m_phase == 2);
        return {own && m_dir, own && !m_dir, m_dir, own, m_phase != 0};
    endfunction

    task automatic begin_turn(input bit d);
        m_phase = 1;
        m_dir   = d;
        m_left  = TURN;
    endtask

    task automatic take_bus(input bit d);
        m_phase = 2;
        m_dir   = d;
        m_last  = d;
        m_cont  = 0;
    endtask

    task automatic model_step(input bit r, input bit ra, input bit rb);
        bit want_cur;
        bit want_opp;
        bit tgt;
        bit limit;
        if (r) begin
            m_phase = 0; m_dir = 0; m_last = 0; m_left = 0; m_cont = 0;
            return;
        end
        want_cur = m_dir ? ra : rb;
        want_opp = m_dir ? rb : ra;
        if (m_phase == 0) begin
            if (ra || rb) begin
                tgt = (ra && rb) ? !m_last : ra;
                if (tgt == m_dir) take_bus(tgt);
                else              begin_turn(tgt);
            end
        end else if (m_phase == 1) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                if (want_cur)      take_bus(m_dir);
                else if (want_opp) begin_turn(!m_dir);
                else               m_phase = 0;
            end
        end else begin
            if (want_opp) m_cont = m_cont + 1;
`ifdef BI_BUF_CTRL_BURST_LIMIT_EN
            limit = want_opp && (m_cont >= MAXB);
`else
            limit = 1'b0;
`endif
            if (!want_cur || limit) begin
                if (want_opp) begin_turn(!m_dir);
                else          m_phase = 0;
            end
        end
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // leave the caller at the next falling edge to sample outputs.
    task automatic cyc(input bit r, input bit ra, input bit rb);
        rst   = r;
        req_a = ra;
        req_b = rb;
        @(posedge clk);
        model_step(r, ra, rb);
        @(negedge clk);
    endtask

    typedef struct {
        bit         r;
        bit         ra;
        bit         rb;
        logic [4:0] exp;   // {gnt_a, gnt_b, en, oe, busy}
    } vec_t;

    vec_t vecs [NVEC];

    initial begin
        int  n;
        int  m;
        bit  ra;
        bit  rb;
        bit  r;

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        model_step(1'b1, 1'b0, 1'b0);

        // Reset held with both requesting, then A wins the first tie
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 5'b00000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'b00101};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'b00101};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 5'b10111};
        // Drop to idle, re-request in the same direction: no turnaround
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'b00100};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'b10111};
        // Handover A -> B with B waiting
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'b10111};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'b00001};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'b00001};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 5'b01011};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 5'b01011};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 5'b00000};
        // Target withdraws mid-turn, other side asks: second turn, then idle
        vecs[14] = '{1'b0, 1'b1, 1'b0, 5'b00101};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 5'b00101};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 5'b00001};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 5'b00001};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 5'b00000};
        // Round-robin ties: A then B
        vecs[19] = '{1'b0, 1'b1, 1'b1, 5'b00101};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 5'b00101};
        vecs[21] = '{1'b0, 1'b1, 1'b1, 5'b10111};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 5'b00100};
        vecs[23] = '{1'b0, 1'b1, 1'b1, 5'b00001};
        vecs[24] = '{1'b0, 1'b1, 1'b1, 5'b00001};
        vecs[25] = '{1'b0, 1'b1, 1'b1, 5'b01011};
        // Reset mid-turn clears everything immediately
        vecs[26] = '{1'b0, 1'b1, 1'b0, 5'b00101};
        vecs[27] = '{1'b1, 1'b1, 1'b1, 5'b00000};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 5'b00000};

        @(negedge clk);
        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].r, vecs[i].ra, vecs[i].rb);
            check($sformatf("vec[%0d] {gnt_a,gnt_b,en,oe,busy}", i), int'(dut_o), int'(vecs[i].exp));
        end

        // Owner holding its request while the other side waits
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10 && !gnt_a; k++) cyc(1'b0, 1'b1, 1'b0);
        check("burst_setup gnt_a", int'(gnt_a), 1);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            check("burst no overlap", int'(gnt_a && gnt_b), 0);
            if (!gnt_a) break;
            n++;
        end
`ifdef BI_BUF_CTRL_BURST_LIMIT_EN
        check("burst cycles held by A", n, MAXB - 1);
        m = 0;
        for (int k = 0; k < 20 && !gnt_b; k++) begin
            cyc(1'b0, 1'b1, 1'b1);
            m++;
        end
        check("burst turn to gnt_b", m, TURN);
`else
        check("hold cycles by A", n, 30);
        m = 0;
`endif

        // Randomized traffic against the model
        cyc(1'b1, 1'b0, 1'b0);
        ra = 1'b0; rb = 1'b0;
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            cyc(r, ra, rb);
            check($sformatf("rand[%0d] {gnt_a,gnt_b,en,oe,busy}", k), int'(dut_o), int'(model_out()));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_bi_buf_ctrl
`default_nettype wire
